// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared CPU-wide constants and types.
//
// Contents:
//   XLEN             datapath width in bits
//   INSTR_BYTES      size of one instruction in bytes (default PC step)
//   DEFAULT_RESET_PC default fetch address after reset
//   fetch_state_t    fetch sequencer states {IDLE, RUN, HALTED}
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg -- IF/ID pipeline register with a valid/ready style handshake.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop the held entry (id_valid -> 0), no load this cycle
//   fetch_en        upstream is allowed to present a new instruction
//   id_ready        decode accepts the held entry this cycle
//   in_instr/in_pc/in_pc_next  candidate entry from the fetch side
//   load            a new entry is captured at this clock edge (PC advances)
//   id_valid/id_instr/id_pc/id_pc_plus4  registered entry towards decode
module if_id_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            fetch_en,
  input  logic            id_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_next,
  output logic            load,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  // The slot is free when empty or when decode is taking the current entry.
  // A flush always wins so a redirect never captures the stale fetch address.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    load       = fetch_en && !flush && (!valid_q || id_ready);
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = in_instr;
      pc_d       = in_pc;
      pc_plus4_d = in_pc_next;
    end else if (id_ready) begin
      // Nothing new to load (halted or idle): the held entry drains.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc       = pc_q;
  assign id_pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch: PC register, IDLE/RUN/HALTED sequencer
// and the IF/ID output register (if_id_reg).
//
// Parameters:
//   RESET_PC  fetch address loaded on reset
//   PC_STEP   sequential PC increment in bytes
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem_addr         address to the combinational instruction memory (= pc)
//   imem_data         instruction word for imem_addr, same cycle
//   redirect_valid    control-flow change request (highest priority)
//   redirect_target   new fetch address when redirect_valid=1
//   halt_req          stop fetching after the current instruction is captured
//   id_ready          decode accepts the id_* entry this cycle
//   id_valid/id_instr/id_pc/id_pc_plus4  IF/ID register outputs
//   fetch_fault       sticky misaligned-redirect flag (FETCH_ALIGN_CHECK_EN only)
//
// Build option:
//   FETCH_ALIGN_CHECK_EN  when defined, a misaligned redirect halts fetch and
//                         raises fetch_fault; otherwise the target's low two
//                         bits are cleared before loading pc.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     PC_STEP  = INSTR_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt_req,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            fetch_fault
`else
  output logic [XLEN-1:0] id_pc_plus4
`endif
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            halt_pend_q, halt_pend_d;
  logic [XLEN-1:0] pc_next;
  logic            fetch_en;
  logic            load;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            fault_q, fault_d;
`endif

  // Plain 32-bit add: wraps modulo 2^32 with no carry out by design.
  assign pc_next   = pc_q + STEP;
  assign fetch_en  = (state_q == RUN);
  assign imem_addr = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    halt_pend_d = halt_pend_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d     = fault_q;
`endif

    if (redirect_valid) begin
      // Redirect overrides everything, including a same-cycle halt_req.
      halt_pend_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_target[1:0] != 2'b00) begin
        fault_d = 1'b1;
        state_d = HALTED;
      end else begin
        pc_d    = redirect_target;
        state_d = RUN;
      end
`else
      pc_d    = redirect_target & ~32'h0000_0003;
      state_d = RUN;
`endif
    end else begin
      unique case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (load) begin
            pc_d = pc_next;
            // Halt only once the current instruction has been captured; a
            // request seen during a stall waits for that capture.
            if (halt_req || halt_pend_q) begin
              state_d     = HALTED;
              halt_pend_d = 1'b0;
            end
          end else if (halt_req) begin
            halt_pend_d = 1'b1;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      halt_pend_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      halt_pend_q <= halt_pend_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q     <= fault_d;
`endif
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault = fault_q;
`endif

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_valid),
    .fetch_en    (fetch_en),
    .id_ready    (id_ready),
    .in_instr    (imem_data),
    .in_pc       (pc_q),
    .in_pc_next  (pc_next),
    .load        (load),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4)
  );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch address loaded on reset.
REQ-002 Parameter PC_STEP, default 4, SHALL be the sequential PC increment in bytes.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 imem_addr  output  32  SHALL be the address to the combinational instruction memory.
REQ-006 imem_data  input  32  SHALL be the instruction word for imem_addr, valid in the same cycle.
REQ-007 redirect_valid  input  1  SHALL request a control-flow change this cycle.
REQ-008 redirect_target  input  32  SHALL be the new fetch address, sampled when redirect_valid=1.
REQ-009 halt_req  input  1  SHALL request fetch stop after the current instruction is captured.
REQ-010 id_ready  input  1  SHALL indicate that decode accepts id_* this cycle.
REQ-011 id_valid  output  1  SHALL indicate that id_instr/id_pc/id_pc_plus4 hold a valid instruction.
REQ-012 id_instr, id_pc, id_pc_plus4  output  32 each  SHALL be the registered instruction, its address, and its address+PC_STEP.
REQ-013 fetch_fault  output  1  SHALL be the sticky misaligned-redirect flag (present only with FETCH_ALIGN_CHECK_EN).

Function
REQ-014 imem_addr SHALL equal the internal pc register combinationally.
REQ-015 FSM states: IDLE, RUN, HALTED; IDLE SHALL last exactly one cycle after reset, with id_valid=0, then move to RUN.
REQ-016 In RUN the output register SHALL load {imem_data, pc, pc+PC_STEP} when id_valid=0 or id_ready=1, and pc SHALL advance by PC_STEP in that same cycle.
REQ-017 Stall (id_valid=1, id_ready=0): id_* and pc SHALL hold stable; no instruction SHALL be dropped or duplicated.
REQ-018 Redirect (cycle N) SHALL have top priority: id_valid=0 at N+1 (flush, including a stalled entry), pc=redirect_target at N+1, first redirected instruction valid at N+2.
REQ-019 halt_req in RUN SHALL capture the current instruction normally, then enter HALTED; in HALTED, pc holds and no new load occurs; a valid entry drains on id_ready.
REQ-020 HALTED SHALL be left only by redirect (to RUN with the REQ-018 timing) or by rst.
REQ-021 Simultaneous redirect_valid and halt_req SHALL take the redirect and ignore halt_req.
REQ-022 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 32'h0000_0000, with no flag.

Reset
REQ-023 On rst=1 at a clock edge: pc=RESET_PC, state=IDLE, id_valid=0, id_instr=id_pc=id_pc_plus4=0, fetch_fault=0.
REQ-024 rst SHALL override redirect, halt and stall, including mid-stall and in HALTED.

Configuration
REQ-025 With FETCH_ALIGN_CHECK_EN defined, a redirect with target[1:0]!=0 SHALL leave pc unchanged, flush id_valid, set fetch_fault=1 (sticky until rst), and enter HALTED.
REQ-026 Without FETCH_ALIGN_CHECK_EN, fetch_fault SHALL not exist, and redirect_target[1:0] SHALL be forced to 2'b00 before loading pc.

Structure
REQ-027 Shared package cpu_pkg SHALL hold XLEN=32, INSTR_BYTES=4, default RESET_PC, and the fetch_state_t enum {IDLE, RUN, HALTED}.
REQ-028 The IF/ID output register with the load/hold handshake SHALL be one sub-module, if_id_reg; pc and the FSM stay in fetch_stage.

Verification
REQ-029 Reset then id_ready=1 for 4 cycles -> id_pc sequence 0x0, 0x4, 0x8, 0xC starting the cycle after IDLE; id_pc_plus4=id_pc+4.
REQ-030 id_ready=0 for 3 cycles while id_pc=0x8 -> id_pc and id_instr stable, imem_addr=0xC held; id_ready=1 -> next id_pc=0xC.
REQ-031 Redirect to 0x100 during a stall at id_pc=0x8 -> id_valid=0 next cycle, then id_pc=0x100; 0x8 is never re-presented.
REQ-032 halt_req at pc=0x10 -> 0x10 delivered, then no new id_valid; redirect to 0x40 -> id_pc=0x40 two cycles later.
REQ-033 RESET_PC=32'hFFFF_FFF8 -> id_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-034 Redirect to 0x102 -> with FETCH_ALIGN_CHECK_EN: fetch_fault=1, HALTED, pc unchanged; without it: next id_pc=0x100.
